// File: rtl/cr_axis_mux_pkg.sv
// rtl/cr_axis_mux_pkg.sv - shared types and helpers for the multi-channel AXI4-S ingress mux
package cr_axis_mux_pkg;

   localparam int DEF_N_CHAN = 4;
   localparam int DEF_DATA_W = 64;
   localparam int DEF_USER_W = 2;

   // Channel-index width; a single channel still needs a 1-bit tag.
   function automatic int chan_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int CHAN_W = chan_w(DEF_N_CHAN);

   // One buffered beat in the default configuration, packed as stored in the FIFO.
   typedef struct packed {
      logic [DEF_USER_W-1:0] user;
      logic                  last;
      logic [DEF_DATA_W-1:0] data;
   } axis_mux_word_t;

   typedef enum logic [0:0] {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/cr_axi4s_ib_mux_if.sv
// rtl/cr_axi4s_ib_mux_if.sv - bus bundle for cr_axi4s_ib_mux (timeout_err only with CR_AXIS_IB_MUX_TIMEOUT_EN)
interface cr_axi4s_ib_mux_if #(
   parameter int N_CHAN = 4,
   parameter int DATA_W = 64,
   parameter int USER_W = 2
);
   import cr_axis_mux_pkg::*;

   localparam int CW = chan_w(N_CHAN);

   logic [N_CHAN-1:0]        ib_tvalid;
   logic [N_CHAN-1:0]        ib_tready;
   logic [N_CHAN*DATA_W-1:0] ib_tdata;
   logic [N_CHAN-1:0]        ib_tlast;
   logic [N_CHAN*USER_W-1:0] ib_tuser;

   logic                     ob_rd;
   logic                     ob_empty;
   logic                     ob_aempty;
   logic [DATA_W-1:0]        ob_data;
   logic                     ob_last;
   logic [USER_W-1:0]        ob_user;
   logic [CW-1:0]            ob_chan;
   logic                     proto_err;
`ifdef CR_AXIS_IB_MUX_TIMEOUT_EN
   logic                     timeout_err;

   modport slave (
      input  ib_tvalid, ib_tdata, ib_tlast, ib_tuser, ob_rd,
      output ib_tready, ob_empty, ob_aempty, ob_data, ob_last, ob_user, ob_chan,
             proto_err, timeout_err
   );
   modport master (
      output ib_tvalid, ib_tdata, ib_tlast, ib_tuser, ob_rd,
      input  ib_tready, ob_empty, ob_aempty, ob_data, ob_last, ob_user, ob_chan,
             proto_err, timeout_err
   );
`else
   modport slave (
      input  ib_tvalid, ib_tdata, ib_tlast, ib_tuser, ob_rd,
      output ib_tready, ob_empty, ob_aempty, ob_data, ob_last, ob_user, ob_chan,
             proto_err
   );
   modport master (
      output ib_tvalid, ib_tdata, ib_tlast, ib_tuser, ob_rd,
      input  ib_tready, ob_empty, ob_aempty, ob_data, ob_last, ob_user, ob_chan,
             proto_err
   );
`endif

endinterface

// File: rtl/cr_axis_mux_fifo.sv
// rtl/cr_axis_mux_fifo.sv - single-channel flop FIFO with registered ready (afull) and aempty
module cr_axis_mux_fifo #(
   parameter int WORD_W       = 67,
   parameter int N_ENTRIES    = 16,
   parameter int N_AFULL_VAL  = 3,
   parameter int N_AEMPTY_VAL = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_i,
   input  logic [WORD_W-1:0] wdata_i,
   input  logic              rd_i,
   output logic [WORD_W-1:0] rdata_o,
   output logic              empty_o,
   output logic              ready_o,
   output logic              aempty_o
);

   localparam int PTR_W = $clog2(N_ENTRIES);
   localparam int CNT_W = PTR_W + 1;

   logic [WORD_W-1:0] mem_q [N_ENTRIES];
   logic [PTR_W-1:0]  wptr_q, wptr_d;
   logic [PTR_W-1:0]  rptr_q, rptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ready_q, ready_d;
   logic              aempty_q, aempty_d;
   logic              pop;

   assign pop      = rd_i && (cnt_q != '0);
   assign rdata_o  = mem_q[rptr_q];
   assign empty_o  = (cnt_q == '0);
   assign ready_o  = ready_q;
   assign aempty_o = aempty_q;

   // Pointer/count update; ready looks at the post-cycle fill so one in-flight beat always fits.
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (wr_i) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      case ({wr_i, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
      ready_d  = (N_ENTRIES - int'(cnt_d)) > N_AFULL_VAL;
      aempty_d = int'(cnt_d) <= N_AEMPTY_VAL;
   end

   // Control state with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         cnt_q    <= '0;
         ready_q  <= 1'b0;
         aempty_q <= 1'b1;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         cnt_q    <= cnt_d;
         ready_q  <= ready_d;
         aempty_q <= aempty_d;
      end
   end

   // Storage array; contents need no reset since empty hides stale words.
   always_ff @(posedge clk) begin
      if (wr_i) mem_q[wptr_q] <= wdata_i;
   end

   a_no_overflow : assert property (@(posedge clk) disable iff (rst)
      !(wr_i && (cnt_q == CNT_W'(N_ENTRIES)) && !rd_i));

endmodule

// File: rtl/cr_axi4s_ib_mux.sv
// rtl/cr_axi4s_ib_mux.sv - N-channel AXI4-S ingress with frame round-robin merge; CR_AXIS_IB_MUX_TIMEOUT_EN adds stall timeout
module cr_axi4s_ib_mux
   import cr_axis_mux_pkg::*;
#(
   parameter int N_CHAN       = 4,
   parameter int DATA_W       = 64,
   parameter int USER_W       = 2,
   parameter int N_ENTRIES    = 16,
   parameter int N_AFULL_VAL  = 3,
   parameter int N_AEMPTY_VAL = 1,
   parameter int TIMEOUT      = 1024
) (
   input logic                clk,
   input logic                rst,
   cr_axi4s_ib_mux_if.slave   bus
);

   localparam int CW     = chan_w(N_CHAN);
   localparam int WORD_W = USER_W + 1 + DATA_W;

   localparam logic [0:0] ST_IDLE   = 1'(ARB_IDLE);
   localparam logic [0:0] ST_LOCKED = 1'(ARB_LOCKED);

   logic [0:0]        state_q, state_d;
   logic [CW-1:0]     grant_q, grant_d;
   logic [CW-1:0]     rr_ptr_q, rr_ptr_d;
   logic              proto_err_q, proto_err_d;

   logic [N_CHAN-1:0] f_wr, f_rd, f_empty, f_ready, f_aempty;
   logic [WORD_W-1:0] f_head [N_CHAN];

   logic [CW-1:0]     pick;
   logic              pick_vld;
   logic              synth;
   logic              pop;

   logic              ob_empty_w, ob_aempty_w, ob_last_w;
   logic [DATA_W-1:0] ob_data_w;
   logic [USER_W-1:0] ob_user_w;
   logic [CW-1:0]     ob_chan_w;

   genvar c;
   generate
      for (c = 0; c < N_CHAN; c++) begin : g_chan
         assign f_wr[c] = bus.ib_tvalid[c] & f_ready[c];
         assign f_rd[c] = pop && !synth && (grant_q == CW'(c));

         cr_axis_mux_fifo #(
            .WORD_W       (WORD_W),
            .N_ENTRIES    (N_ENTRIES),
            .N_AFULL_VAL  (N_AFULL_VAL),
            .N_AEMPTY_VAL (N_AEMPTY_VAL)
         ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .wr_i     (f_wr[c]),
            .wdata_i  ({bus.ib_tuser[c*USER_W +: USER_W], bus.ib_tlast[c],
                        bus.ib_tdata[c*DATA_W +: DATA_W]}),
            .rd_i     (f_rd[c]),
            .rdata_o  (f_head[c]),
            .empty_o  (f_empty[c]),
            .ready_o  (f_ready[c]),
            .aempty_o (f_aempty[c])
         );
      end
   endgenerate

   assign bus.ib_tready = f_ready;

`ifdef CR_AXIS_IB_MUX_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);

   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            to_err_q, to_err_d;

   assign synth           = (state_q == ST_LOCKED) && (to_cnt_q == TO_W'(TIMEOUT));
   assign bus.timeout_err = to_err_q;

   // Count empty cycles of the locked channel; the error pulse lines up with the first synthetic-word cycle.
   always_comb begin
      to_cnt_d = to_cnt_q;
      if ((state_q != ST_LOCKED) || pop) to_cnt_d = '0;
      else if (f_empty[grant_q] && !synth) to_cnt_d = to_cnt_q + 1'b1;
      to_err_d = (to_cnt_d == TO_W'(TIMEOUT)) && !synth;
   end

   // Timeout counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt_q <= '0;
         to_err_q <= 1'b0;
      end else begin
         to_cnt_q <= to_cnt_d;
         to_err_q <= to_err_d;
      end
   end
`else
   assign synth = 1'b0;
`endif

   // Round-robin pick: lowest offset from rr_ptr among non-empty FIFOs wins.
   always_comb begin
      int idx;
      idx      = 0;
      pick     = '0;
      pick_vld = 1'b0;
      for (int i = N_CHAN - 1; i >= 0; i--) begin
         idx = int'(rr_ptr_q) + i;
         if (idx >= N_CHAN) idx = idx - N_CHAN;
         if (!f_empty[idx]) begin
            pick     = CW'(idx);
            pick_vld = 1'b1;
         end
      end
   end

   // Output head: only the locked channel (or the synthetic word) is ever visible.
   always_comb begin
      ob_empty_w  = 1'b1;
      ob_aempty_w = 1'b1;
      ob_data_w   = '0;
      ob_last_w   = 1'b0;
      ob_user_w   = '0;
      ob_chan_w   = '0;
      if (state_q == ST_LOCKED) begin
         ob_chan_w   = grant_q;
         ob_aempty_w = f_aempty[grant_q];
         if (synth) begin
            ob_empty_w = 1'b0;
            ob_last_w  = 1'b1;
            ob_user_w  = '1;
         end else if (!f_empty[grant_q]) begin
            ob_empty_w = 1'b0;
            {ob_user_w, ob_last_w, ob_data_w} = f_head[grant_q];
         end
      end
   end

   assign pop = bus.ob_rd && !ob_empty_w;

   assign bus.ob_empty  = ob_empty_w;
   assign bus.ob_aempty = ob_aempty_w;
   assign bus.ob_data   = ob_data_w;
   assign bus.ob_last   = ob_last_w;
   assign bus.ob_user   = ob_user_w;
   assign bus.ob_chan   = ob_chan_w;
   assign bus.proto_err = proto_err_q;

   // Arbiter FSM: one IDLE cycle per frame, release on popping the last word.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      proto_err_d = proto_err_q | (bus.ob_rd & ob_empty_w);
      case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               grant_d = pick;
               state_d = ST_LOCKED;
            end
         end
         default: begin
            if (pop && ob_last_w) begin
               state_d  = ST_IDLE;
               rr_ptr_d = (int'(grant_q) == N_CHAN - 1) ? '0 : grant_q + 1'b1;
            end
         end
      endcase
   end

   // Arbiter state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         grant_q     <= '0;
         rr_ptr_q    <= '0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_ptr_q    <= rr_ptr_d;
         proto_err_q <= proto_err_d;
      end
   end

endmodule

// File: doc/cr_axi4s_ib_mux.md
Name: cr_axi4s_ib_mux

Overview:
Parametrised multi-channel AXI4-Stream ingress stage for the TLV-parser front end; next generation of the single-channel AXI4-S slave buffer.
Each of N_CHAN input streams gets its own FIFO.
A frame-granular round-robin arbiter merges the streams onto one read-style (empty/aempty/rd) interface that feeds cr_tlvp directly. Each output word is tagged with its source channel.

Parameters:
N_CHAN, 4, number of input AXI4-S channels (1..8)
DATA_W, 64, tdata width in bits (multiple of 8)
USER_W, 2, tuser width
N_ENTRIES, 16, per-channel FIFO depth (power of 2, >=4)
N_AFULL_VAL, 3, tready deasserts when free entries <= N_AFULL_VAL
N_AEMPTY_VAL, 1, ob_aempty asserts when granted FIFO count <= N_AEMPTY_VAL
TIMEOUT, 1024, stall cycles before forced grant release (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
ib_tvalid  in  N_CHAN  per-channel valid
ib_tready  out  N_CHAN  per-channel ready
ib_tdata  in  N_CHAN*DATA_W  per-channel data, channel c at [c*DATA_W +: DATA_W]
ib_tlast  in  N_CHAN  end of frame
ib_tuser  in  N_CHAN*USER_W  sideband
ob_rd  in  1  pop head of granted channel
ob_empty  out  1  no word available
ob_aempty  out  1  granted FIFO almost empty
ob_data  out  DATA_W  head word
ob_last  out  1  head word is tlast
ob_user  out  USER_W  head tuser
ob_chan  out  clog2(N_CHAN) (min 1)  source channel of head word
proto_err  out  1  sticky: ob_rd while ob_empty

Behaviour:
- Reset (async assert, sync deassert internal): all FIFOs emptied. ib_tready=0, ob_empty=1, ob_aempty=1, ob_data/ob_last/ob_user/ob_chan=0, proto_err=0. State=IDLE, rr_ptr=0.
- ib_tready[c] is registered: it is 1 iff the free entries after the current cycle exceed N_AFULL_VAL. This gives a skid margin, so a beat with tvalid&tready is never dropped. A write into a full FIFO is impossible by construction; an assertion covers it.
- Per-channel FIFO is flop-based and stores {tuser, tlast, tdata}. Write-to-read latency: a word accepted in cycle t is visible at ob_* in cycle t+1 at the earliest.
- Arbiter FSM, states IDLE and LOCKED:
  - IDLE: requesters are the channels whose FIFOs are non-empty. Pick the first requester at or after rr_ptr (wrapping). Register grant and go to LOCKED. ob_empty=1 while in IDLE, so arbitration costs exactly 1 cycle per frame.
  - LOCKED: ob_* is driven combinationally from the granted FIFO head, and ob_empty mirrors that FIFO's empty flag.
  - ob_rd & !ob_empty pops the head word. If the popped word has last=1: go to IDLE and set rr_ptr=(grant+1) mod N_CHAN.
  - Frames are never interleaved. Other channels keep filling their FIFOs while one channel is locked.
- Same-cycle events: a push and a pop on the same FIFO leave its count unchanged. A full-depth FIFO with a simultaneous pop and push is legal.
- ob_rd while ob_empty: no pop, state unchanged, proto_err set to 1 (cleared only by rst).
- N_CHAN=1: the arbiter degenerates but keeps the 1-cycle IDLE gap between frames.
- rst mid-frame: the partial frame is discarded. Upstream must restart at a frame boundary.

Optional Feature:
Macro: CR_AXIS_IB_MUX_TIMEOUT_EN
- With the macro: in LOCKED, a counter increments each cycle the granted FIFO is empty and resets on any pop. When it reaches TIMEOUT:
  - for one cycle, the block presents a synthetic word with last=1, data=0 and user='1;
  - extra output port timeout_err pulses for 1 cycle;
  - after that word is popped, state returns to IDLE.
  This guarantees that a stalled source cannot starve the other channels.
- Without the macro: no counter and no timeout_err port; LOCKED waits indefinitely.

Decomposition:
- Shared package cr_axis_mux_pkg holds:
  - typedef axis_mux_word_t {user, last, data}
  - the arbiter state enum {IDLE, LOCKED}
  - constant CHAN_W = clog2(N_CHAN)
- One natural sub-module: cr_axis_mux_fifo (single-channel flop FIFO with registered afull/aempty and count), instantiated N_CHAN times by generate.
- Round-robin select stays in the top level.

Test Plan:
- Reset, then 4-beat frame on channel 2 (data 0x11..0x44, last on beat 4) with ob_rd held high -> ob_empty=0 from cycle 2, ob_chan=2, 4 words in order, ob_last only on 0x44, then IDLE.
- Frames on ch0 (3 beats) and ch1 (2 beats) arrive simultaneously, ob_rd=1 -> ch0 frame complete, then 1 empty cycle, then ch1 frame; no interleaving.
- All 4 channels hold 1-beat frames and are continuously refilled -> grant order 0,1,2,3,0,...
- Channel 0 sends 20 beats with ob_rd=0 (N_ENTRIES=16, AFULL=3) -> ib_tready[0] falls once 13 entries are occupied, no beat lost, all 20 words read back intact.
- ob_rd pulsed while ob_empty=1 -> proto_err=1 and stays 1; state and data unaffected.
- CR_AXIS_IB_MUX_TIMEOUT_EN, TIMEOUT=8: ch3 sends 2 beats without last, then idles -> after 8 empty cycles a synthetic last word (data 0) appears, timeout_err pulses once, and a pending ch0 frame is granted next.
